// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the byte-wide memory arbiter and its helpers.
package mem_arbiter_pkg;

    // Default width of ROB id tags.
    localparam int ROB_SIZE_WIDTH = 4;

    // Load type codes as driven by the load buffer.
    localparam int         LOAD_TYPE_NUM_WIDTH = 3;
    localparam logic [2:0] LOAD_BYTE   = 3'd0;
    localparam logic [2:0] LOAD_HALF   = 3'd1;
    localparam logic [2:0] LOAD_WORD   = 3'd2;
    localparam logic [2:0] LOAD_BYTE_U = 3'd3;
    localparam logic [2:0] LOAD_HALF_U = 3'd4;

    // Store width codes as driven by the ROB commit port.
    localparam logic [1:0] STORE_BYTE = 2'd0;
    localparam logic [1:0] STORE_HALF = 2'd1;
    localparam logic [1:0] STORE_WORD = 2'd2;

    // addr[17:16] value that selects the IO window (UART).
    localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

    // Sequencer states; the encoding is visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_t;

    // Owner of the access currently in service.
    typedef enum logic [1:0] {
        SRC_FETCH = 2'd0,
        SRC_LOAD  = 2'd1,
        SRC_STORE = 2'd2
    } arb_src_t;

    // Number of RAM byte cycles for a load type.
    function automatic logic [2:0] load_bytes(input logic [2:0] t);
        case (t)
            LOAD_BYTE, LOAD_BYTE_U: return 3'd1;
            LOAD_HALF, LOAD_HALF_U: return 3'd2;
            default:                return 3'd4;
        endcase
    endfunction

    // Number of RAM byte cycles for a store width.
    function automatic logic [2:0] store_bytes(input logic [1:0] w);
        case (w)
            STORE_BYTE: return 3'd1;
            STORE_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

    // Little-endian byte lane select.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// Combinational byte assembly plus sign/zero extension of a load result.
// The final byte comes straight from the RAM bus so the result is ready on
// the same edge the last byte is accepted; the load/store buffer forwarding
// path reuses this block with last_idx pointing at an already-valid lane.
module load_extend
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] part_word,
    input  logic [7:0]  last_byte,
    input  logic [1:0]  last_idx,
    input  logic [2:0]  ld_type,
    output logic [31:0] value
);

    logic [31:0] word;

    // Merge the last byte into its lane, then extend according to the type.
    always_comb begin
        word = part_word;
        case (last_idx)
            2'd0:    word[7:0]   = last_byte;
            2'd1:    word[15:8]  = last_byte;
            2'd2:    word[23:16] = last_byte;
            default: word[31:24] = last_byte;
        endcase
        case (ld_type)
            LOAD_BYTE:   value = {{24{word[7]}}, word[7:0]};
            LOAD_HALF:   value = {{16{word[15]}}, word[15:0]};
            LOAD_BYTE_U: value = {24'd0, word[7:0]};
            LOAD_HALF_U: value = {16'd0, word[15:0]};
            default:     value = word;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Sole owner of the byte-wide RAM/IO port. Arbitrates committed stores,
// buffered loads and instruction fetches, and sequences each into 1/2/4
// single-byte RAM cycles.
//
// Handshakes: st_valid and ld_valid are one-cycle pulses that fill a
// one-entry slot. ld_valid may only pulse while mem_busy is 0; st_valid may
// only pulse when no earlier store is still awaiting its st_done. if_req is
// a level held until the if_done pulse. Every *_done is a one-cycle pulse
// (stretched while rdy_in is 0) that carries its result in the same cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         ROB_W = ROB_SIZE_WIDTH,
    parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_done,
    output logic [31:0]      if_inst,
    input  logic             ld_valid,
    input  logic [2:0]       ld_type,
    input  logic [31:0]      ld_addr,
    input  logic [ROB_W-1:0] ld_rob_id,
    output logic             ld_done,
    output logic [ROB_W-1:0] ld_rob_id_out,
    output logic [31:0]      ld_value,
    input  logic             st_valid,
    input  logic [1:0]       st_width,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_done,
    output logic             mem_busy,
    input  logic [7:0]       mem_din,
    output logic [7:0]       mem_dout,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    input  logic             io_buffer_full,
    output arb_state_t       dbg_state
);

    arb_state_t       state_q, state_n;
    arb_src_t         src_q, src_n;
    logic [1:0]       cnt_q, cnt_n;
    logic [2:0]       nbytes_q, nbytes_n;
    logic [31:0]      addr_q, addr_n;
    logic [2:0]       type_q, type_n;
    logic [31:0]      buf_q, buf_n;

    logic             ld_pend_q, ld_pend_n;
    logic [2:0]       ld_type_q, ld_type_n;
    logic [31:0]      ld_addr_q, ld_addr_n;
    logic [ROB_W-1:0] ld_rob_q, ld_rob_n;

    logic             st_pend_q, st_pend_n;
    logic [1:0]       st_width_q, st_width_n;
    logic [31:0]      st_addr_q, st_addr_n;
    logic [31:0]      st_data_q, st_data_n;

    logic             if_done_n, ld_done_n, st_done_n;
    logic [31:0]      if_inst_n, ld_value_n;
    logic [ROB_W-1:0] ld_rob_out_n;
    logic [7:0]       mem_dout_n;
    logic [31:0]      mem_a_n;
    logic             mem_wr_n;

    logic             grant_st, grant_ld;
    logic [1:0]       cnt_inc;
    logic             last_byte;
    logic [31:0]      next_a;
    logic             stall_grant, stall_next, stall_cur;
    logic [31:0]      ext_value;

    assign cnt_inc     = cnt_q + 2'd1;
    assign last_byte   = (({1'b0, cnt_q} + 3'd1) == nbytes_q);
    assign next_a      = addr_q + {30'd0, cnt_inc};
    // UART writes wait while its buffer is full; reads are never held.
    assign stall_grant = (st_addr_q[17:16] == IO_HI) && io_buffer_full;
    assign stall_next  = (next_a[17:16] == IO_HI) && io_buffer_full;
    assign stall_cur   = (mem_a[17:16] == IO_HI) && io_buffer_full;

    assign mem_busy  = ld_pend_q || (state_q == ST_READ && src_q == SRC_LOAD);
    assign dbg_state = state_q;

    load_extend u_extend (
        .part_word (buf_q),
        .last_byte (mem_din),
        .last_idx  (cnt_q),
        .ld_type   (type_q),
        .value     (ext_value)
    );

    // Next-state, RAM bus and slot bookkeeping for the sequencer.
    always_comb begin
        state_n      = state_q;
        src_n        = src_q;
        cnt_n        = cnt_q;
        nbytes_n     = nbytes_q;
        addr_n       = addr_q;
        type_n       = type_q;
        buf_n        = buf_q;
        ld_pend_n    = ld_pend_q;
        ld_type_n    = ld_type_q;
        ld_addr_n    = ld_addr_q;
        ld_rob_n     = ld_rob_q;
        st_pend_n    = st_pend_q;
        st_width_n   = st_width_q;
        st_addr_n    = st_addr_q;
        st_data_n    = st_data_q;
        if_done_n    = 1'b0;
        ld_done_n    = 1'b0;
        st_done_n    = 1'b0;
        if_inst_n    = if_inst;
        ld_value_n   = ld_value;
        ld_rob_out_n = ld_rob_id_out;
        mem_dout_n   = mem_dout;
        mem_a_n      = mem_a;
        mem_wr_n     = mem_wr;
        grant_st     = 1'b0;
        grant_ld     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_a_n    = 32'd0;
                mem_wr_n   = 1'b0;
                mem_dout_n = 8'd0;
                cnt_n      = 2'd0;
                buf_n      = 32'd0;
                if (st_pend_q) begin
                    grant_st   = 1'b1;
                    state_n    = ST_WRITE;
                    src_n      = SRC_STORE;
                    addr_n     = st_addr_q;
                    nbytes_n   = store_bytes(st_width_q);
                    mem_a_n    = st_addr_q;
                    mem_dout_n = st_data_q[7:0];
                    mem_wr_n   = !stall_grant;
                end else if (ld_pend_q && !flush_in) begin
                    grant_ld = 1'b1;
                    state_n  = ST_READ;
                    src_n    = SRC_LOAD;
                    addr_n   = ld_addr_q;
                    nbytes_n = load_bytes(ld_type_q);
                    type_n   = ld_type_q;
                    mem_a_n  = ld_addr_q;
                end else if (if_req && !flush_in && !if_done) begin
                    // if_done still high means the fetcher has not yet
                    // dropped if_req for the word it just received.
                    state_n  = ST_READ;
                    src_n    = SRC_FETCH;
                    addr_n   = if_addr;
                    nbytes_n = 3'd4;
                    type_n   = LOAD_WORD;
                    mem_a_n  = if_addr;
                end
            end

            ST_READ: begin
                if (flush_in) begin
                    state_n = ST_IDLE;
                    mem_a_n = 32'd0;
                end else if (last_byte) begin
                    state_n = ST_IDLE;
                    mem_a_n = 32'd0;
                    if (src_q == SRC_LOAD) begin
                        ld_done_n    = 1'b1;
                        ld_value_n   = ext_value;
                        ld_rob_out_n = ld_rob_q;
                    end else begin
                        if_done_n = 1'b1;
                        if_inst_n = ext_value;
                    end
                end else begin
                    case (cnt_q)
                        2'd0:    buf_n[7:0]   = mem_din;
                        2'd1:    buf_n[15:8]  = mem_din;
                        default: buf_n[23:16] = mem_din;
                    endcase
                    cnt_n   = cnt_inc;
                    mem_a_n = next_a;
                end
            end

            ST_WRITE: begin
                if (mem_wr) begin
                    // The byte on the bus is written at this edge.
                    if (last_byte) begin
                        st_done_n  = 1'b1;
                        state_n    = ST_IDLE;
                        mem_wr_n   = 1'b0;
                        mem_a_n    = 32'd0;
                        mem_dout_n = 8'd0;
                    end else begin
                        cnt_n      = cnt_inc;
                        mem_a_n    = next_a;
                        mem_dout_n = byte_sel(st_data_q, cnt_inc);
                        mem_wr_n   = !stall_next;
                    end
                end else begin
                    // Held byte: retry the same address each cycle.
                    mem_wr_n = !stall_cur;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        if (grant_st) st_pend_n = 1'b0;
        if (st_valid) begin
            st_pend_n  = 1'b1;
            st_width_n = st_width;
            st_addr_n  = st_addr;
            st_data_n  = st_data;
        end

        if (grant_ld) ld_pend_n = 1'b0;
        if (ld_valid && !flush_in) begin
            ld_pend_n = 1'b1;
            ld_type_n = ld_type;
            ld_addr_n = ld_addr;
            ld_rob_n  = ld_rob_id;
        end
        if (flush_in) ld_pend_n = 1'b0;
    end

    // State register; everything holds while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q       <= ST_IDLE;
            src_q         <= SRC_FETCH;
            cnt_q         <= 2'd0;
            nbytes_q      <= 3'd0;
            addr_q        <= 32'd0;
            type_q        <= LOAD_WORD;
            buf_q         <= 32'd0;
            ld_pend_q     <= 1'b0;
            ld_type_q     <= LOAD_WORD;
            ld_addr_q     <= 32'd0;
            ld_rob_q      <= '0;
            st_pend_q     <= 1'b0;
            st_width_q    <= STORE_BYTE;
            st_addr_q     <= 32'd0;
            st_data_q     <= 32'd0;
            if_done       <= 1'b0;
            if_inst       <= 32'd0;
            ld_done       <= 1'b0;
            ld_value      <= 32'd0;
            ld_rob_id_out <= '0;
            st_done       <= 1'b0;
            mem_dout      <= 8'd0;
            mem_a         <= 32'd0;
            mem_wr        <= 1'b0;
        end else if (rdy_in) begin
            state_q       <= state_n;
            src_q         <= src_n;
            cnt_q         <= cnt_n;
            nbytes_q      <= nbytes_n;
            addr_q        <= addr_n;
            type_q        <= type_n;
            buf_q         <= buf_n;
            ld_pend_q     <= ld_pend_n;
            ld_type_q     <= ld_type_n;
            ld_addr_q     <= ld_addr_n;
            ld_rob_q      <= ld_rob_n;
            st_pend_q     <= st_pend_n;
            st_width_q    <= st_width_n;
            st_addr_q     <= st_addr_n;
            st_data_q     <= st_data_n;
            if_done       <= if_done_n;
            if_inst       <= if_inst_n;
            ld_done       <= ld_done_n;
            ld_value      <= ld_value_n;
            ld_rob_id_out <= ld_rob_out_n;
            st_done       <= st_done_n;
            mem_dout      <= mem_dout_n;
            mem_a         <= mem_a_n;
            mem_wr        <= mem_wr_n;
        end
    end

endmodule
